vram_arbiter: RTL and testbench

Single-port access controller for the 128x96, 3-bit-per-pixel frame buffer built from the three 16Kx1 colour RAMs (red, green, blue). It shares the common RAM port between the VGA scan-out reader, a pixel writer with a request/acknowledge handshake, and an optional frame-clear sequencer. It sits between the VGA timing/pixel pipeline and the three colour RAM instances, driving their shared EN/WE/ADDR and per-colour DATA_IN, and collecting their DATA_OUT.

---
 rtl/vram_pkg.sv | 24 ++
 rtl/vram_arbiter_if.sv | 42 ++++
 rtl/vram_clear_seq.sv | 42 ++++
 rtl/vram_arbiter.sv | 95 +++++++++
 tb/tb_vram_arbiter.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_pkg.sv
// vram_pkg: shared constants, clear FSM encoding and address helpers for the VRAM arbiter.
package vram_pkg;
    localparam int ROWS = 96;
    localparam int COLS = 128;
    localparam int ADDR_W = 14;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS * COLS - 1);
    localparam int R_BIT = 2;
    localparam int G_BIT = 1;
    localparam int B_BIT = 0;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

    // Frame address is a plain concatenation: row selects a 128-pixel line.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [6:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

    function automatic logic row_ok(input logic [6:0] row);
        return row < 7'(ROWS);
    endfunction
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: client (scan-out read, pixel write, optional clear) and shared RAM port bundle.
// slave  : arbiter side - takes requests and RAM_DO, drives responses and RAM controls.
// master : environment side - pixel clients plus the three colour RAMs.
// Clear signals exist only when VRAM_CLEAR_EN is defined.
interface vram_arbiter_if;
    logic                       rd_req;
    logic [6:0]                 rd_row;
    logic [6:0]                 rd_col;
    logic                       rd_valid;
    logic [2:0]                 rd_rgb;
    logic                       wr_req;
    logic [6:0]                 wr_row;
    logic [6:0]                 wr_col;
    logic [2:0]                 wr_rgb;
    logic                       wr_ack;
`ifdef VRAM_CLEAR_EN
    logic                       clr_req;
    logic [2:0]                 clr_rgb;
    logic                       clr_busy;
`endif
    logic                       ram_en;
    logic                       ram_we;
    logic [vram_pkg::ADDR_W-1:0] ram_addr;
    logic [2:0]                 ram_di;
    logic [2:0]                 ram_do;

    modport slave (
        input  rd_req, rd_row, rd_col, wr_req, wr_row, wr_col, wr_rgb, ram_do,
        output rd_valid, rd_rgb, wr_ack, ram_en, ram_we, ram_addr, ram_di
`ifdef VRAM_CLEAR_EN
        , input clr_req, clr_rgb, output clr_busy
`endif
    );

    modport master (
        output rd_req, rd_row, rd_col, wr_req, wr_row, wr_col, wr_rgb, ram_do,
        input  rd_valid, rd_rgb, wr_ack, ram_en, ram_we, ram_addr, ram_di
`ifdef VRAM_CLEAR_EN
        , output clr_req, clr_rgb, input clr_busy
`endif
    );
endinterface

// File: rtl/vram_clear_seq.sv
// vram_clear_seq: frame-clear FSM, walks addresses 0..LAST_ADDR with a latched colour.
// Ports: i_clk, i_rst (async, active high), i_start (clear request), i_rgb (colour sampled on
// accept), i_stall (a read owns the RAM this cycle), o_req (clear wants the RAM, also busy),
// o_addr / o_rgb (address and colour of the pending clear write).
module vram_clear_seq
    import vram_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [2:0]        i_rgb,
    input  logic              i_stall,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [2:0]        o_rgb
);
    clr_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_rgb;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CLR_IDLE;
            r_addr  <= '0;
            r_rgb   <= '0;
        end else if (r_state == CLR_IDLE) begin
            if (i_start) begin
                r_state <= CLR_CLEAR;
                r_addr  <= '0;
                r_rgb   <= i_rgb;
            end
        end else if (!i_stall) begin
            // This cycle's address is being issued by the arbiter; step past it.
            r_addr  <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
            r_state <= (r_addr == LAST_ADDR) ? CLR_IDLE : CLR_CLEAR;
        end
    end

    assign o_req  = (r_state == CLR_CLEAR);
    assign o_addr = r_addr;
    assign o_rgb  = r_rgb;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port frame-buffer controller, fixed priority read > clear > write.
// Ports: i_clk, i_rst (async, active high), bus (vram_arbiter_if.slave) carrying the scan-out
// read, the pixel write handshake, the optional clear controls and the shared RAM port.
// Optional feature: VRAM_CLEAR_EN adds the frame-clear sequencer and its clr_* signals.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    vram_arbiter_if.slave  bus
);
    logic              w_rd_in;
    logic              w_wr_in;
    logic              w_clr_req;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [2:0]        w_clr_rgb;

    logic              r_rd_p1;
    logic              r_rd_oob_p1;
    logic              r_rd_valid;
    logic              r_rd_oob;
    logic              r_wr_ack;
    logic              r_ram_en;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [2:0]        r_ram_di;

    assign w_rd_in = row_ok(bus.rd_row);
    assign w_wr_in = row_ok(bus.wr_row);

`ifdef VRAM_CLEAR_EN
    vram_clear_seq u_clear (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (bus.clr_req),
        .i_rgb   (bus.clr_rgb),
        .i_stall (bus.rd_req),
        .o_req   (w_clr_req),
        .o_addr  (w_clr_addr),
        .o_rgb   (w_clr_rgb)
    );
    assign bus.clr_busy = w_clr_req;
`else
    assign w_clr_req  = 1'b0;
    assign w_clr_addr = '0;
    assign w_clr_rgb  = '0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_p1     <= 1'b0;
            r_rd_oob_p1 <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_oob    <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_di    <= '0;
        end else begin
            // Two-stage read tag: RAM samples the address one edge later, data follows.
            r_rd_p1     <= bus.rd_req;
            r_rd_oob_p1 <= bus.rd_req & ~w_rd_in;
            r_rd_valid  <= r_rd_p1;
            r_rd_oob    <= r_rd_oob_p1;
            r_wr_ack    <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            if (bus.rd_req) begin
                r_ram_en   <= w_rd_in;
                r_ram_addr <= pix_addr(bus.rd_row, bus.rd_col);
            end else if (w_clr_req) begin
                r_ram_en   <= 1'b1;
                r_ram_we   <= 1'b1;
                r_ram_addr <= w_clr_addr;
                r_ram_di   <= w_clr_rgb;
            end else if (bus.wr_req && !r_wr_ack) begin
                // The ack cycle blocks a regrant, so a held request issues only once.
                r_wr_ack   <= 1'b1;
                r_ram_en   <= w_wr_in;
                r_ram_we   <= w_wr_in;
                r_ram_addr <= pix_addr(bus.wr_row, bus.wr_col);
                r_ram_di   <= bus.wr_rgb;
            end
        end
    end

    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_rgb   = (r_rd_valid && !r_rd_oob) ? bus.ram_do : 3'b000;
    assign bus.wr_ack   = r_wr_ack;
    assign bus.ram_en   = r_ram_en;
    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_di   = r_ram_di;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized self-checking bench with a frame-level reference model and RAM model.
module tb_vram_arbiter;
    import vram_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    vram_arbiter_if bus();

    vram_arbiter dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    logic [2:0] mem [0:16383];
    logic [2:0] r_do = 3'b000;
    always @(posedge i_clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_di;
            r_do <= mem[bus.ram_addr];
        end
    end
    assign bus.ram_do = r_do;

    logic [2:0] frame [0:16383];
    int         n_chk = 0;
    int         n_pass = 0;
    bit         prev_rd = 0;
    logic [2:0] prev_data = 0;
    bit         ack_prev = 0;
    bit         clearing = 0;
    int         ccnt = 0;
    logic [2:0] ccol = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        bit         cur_rd, cur_oob, grant, cissue, start, w_in;
        logic [2:0] cur_data;
        logic [13:0] ra, wa;
        cur_rd   = bus.rd_req;
        ra       = {bus.rd_row, bus.rd_col};
        cur_oob  = bus.rd_row >= ROWS;
        cur_data = cur_oob ? 3'b000 : frame[ra];
        cissue   = clearing && !cur_rd;
        grant    = bus.wr_req && !cur_rd && !ack_prev && !clearing;
        wa       = {bus.wr_row, bus.wr_col};
        w_in     = bus.wr_row < ROWS;
        start    = 0;
`ifdef VRAM_CLEAR_EN
        start    = bus.clr_req && !clearing;
`endif
        @(posedge i_clk);
        @(negedge i_clk);
        if (cur_rd) check("rd_ram_en", bus.ram_en, !cur_oob);
        check("rd_valid", bus.rd_valid, prev_rd);
        if (prev_rd) check("rd_rgb", bus.rd_rgb, prev_data);
        check("wr_ack", bus.wr_ack, grant);
        if (grant) begin
            check("wr_we", bus.ram_we, w_in);
            if (w_in) begin
                check("wr_addr", bus.ram_addr, wa);
                check("wr_di", bus.ram_di, bus.wr_rgb);
                frame[wa] = bus.wr_rgb;
            end
        end
        if (cissue) begin
            check("clr_we", bus.ram_we, 1);
            check("clr_addr", bus.ram_addr, ccnt);
            check("clr_di", bus.ram_di, ccol);
            frame[ccnt] = ccol;
            if (ccnt == LAST_ADDR) clearing = 0;
            ccnt++;
        end
        if (!grant && !cissue) check("no_we", bus.ram_we, 0);
`ifdef VRAM_CLEAR_EN
        if (start) begin
            clearing = 1;
            ccnt = 0;
            ccol = bus.clr_rgb;
        end
        check("clr_busy", bus.clr_busy, clearing);
`endif
        prev_rd   = cur_rd;
        prev_data = cur_data;
        ack_prev  = grant;
    endtask

    task automatic rand_read(input int pct, input int max_row);
        bus.rd_req = ($urandom_range(0, 99) < pct);
        bus.rd_row = 7'($urandom_range(0, max_row));
        bus.rd_col = 7'($urandom_range(0, 127));
    endtask

    task automatic check_frame(input string tag);
        int bad = 0;
        for (int a = 0; a < ROWS * COLS; a++) if (mem[a] !== frame[a]) bad++;
        check(tag, bad, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_rd_rgb"}, bus.rd_rgb, 0);
        check({tag, "_wr_ack"}, bus.wr_ack, 0);
        check({tag, "_ram_en"}, bus.ram_en, 0);
        check({tag, "_ram_we"}, bus.ram_we, 0);
        check({tag, "_ram_addr"}, bus.ram_addr, 0);
        check({tag, "_ram_di"}, bus.ram_di, 0);
`ifdef VRAM_CLEAR_EN
        check({tag, "_clr_busy"}, bus.clr_busy, 0);
`endif
    endtask

    initial begin
        int n;
        for (int a = 0; a < 16384; a++) begin
            logic [2:0] v;
            v = 3'($urandom);
            if (a == 0) v = 3'b110;
            mem[a] <= v;
            frame[a] = v;
        end
        bus.rd_req = 1; bus.rd_row = 0; bus.rd_col = 0;
        bus.wr_req = 1; bus.wr_row = 1; bus.wr_col = 2; bus.wr_rgb = 3'b111;
`ifdef VRAM_CLEAR_EN
        bus.clr_req = 1; bus.clr_rgb = 3'b011;
`endif
        repeat (2) begin
            @(negedge i_clk);
            check_idle_outputs("reset");
        end
        bus.rd_req = 0; bus.wr_req = 0;
`ifdef VRAM_CLEAR_EN
        bus.clr_req = 0;
`endif
        i_rst = 0;
        step();

        // Preloaded pixel at (0,0) returns two cycles after the request.
        bus.rd_req = 1; bus.rd_row = 0; bus.rd_col = 0;
        step();
        bus.rd_req = 0;
        check("t1_early", bus.rd_valid, 0);
        step();
        check("t1_valid", bus.rd_valid, 1);
        check("t1_rgb", bus.rd_rgb, 3'b110);
        step();

        // Held write: exactly one ack, then readback.
        bus.wr_req = 1; bus.wr_row = 5; bus.wr_col = 9; bus.wr_rgb = 3'b101;
        n = 0;
        do begin step(); n++; end while (!ack_prev && n < 20);
        check("t2_ack", bus.wr_ack, 1);
        check("t2_addr", bus.ram_addr, 14'h0289);
        check("t2_we", bus.ram_we, 1);
        step();
        check("t2_no_reissue", bus.wr_ack, 0);
        bus.wr_req = 0;
        bus.rd_req = 1; bus.rd_row = 5; bus.rd_col = 9;
        step();
        bus.rd_req = 0;
        step();
        check("t2_readback", bus.rd_rgb, 3'b101);

        // Reads win for three cycles, then the waiting write is acked.
        bus.wr_req = 1; bus.wr_row = 7'($urandom_range(0, 95)); bus.wr_col = 7'($urandom);
        bus.wr_rgb = 3'($urandom);
        n = 0;
        repeat (3) begin rand_read(100, 95); step(); n++; end
        bus.rd_req = 0;
        while (!ack_prev && n < 20) begin step(); n++; end
        check("t3_ack_cycle", n, 4);
        bus.wr_req = 0;
        step(); step();

        // Out-of-range read and write.
        bus.rd_req = 1; bus.rd_row = 100; bus.rd_col = 3;
        step();
        bus.rd_req = 0;
        step();
        check("t4_oob_valid", bus.rd_valid, 1);
        check("t4_oob_rgb", bus.rd_rgb, 0);
        bus.wr_req = 1; bus.wr_row = 96; bus.wr_col = 0; bus.wr_rgb = 3'b111;
        step();
        check("t4_oob_ack", bus.wr_ack, 1);
        check("t4_oob_we", bus.ram_we, 0);
        bus.wr_req = 0;
        step();

        // Random traffic against the model.
        repeat (400) begin
            rand_read(40, 103);
            if (ack_prev) bus.wr_req = 0;
            if (!bus.wr_req && $urandom_range(0, 1) == 1) begin
                bus.wr_req = 1;
                bus.wr_row = 7'($urandom_range(0, 100));
                bus.wr_col = 7'($urandom);
                bus.wr_rgb = 3'($urandom);
            end
            step();
        end
        bus.rd_req = 0;
        n = 0;
        while (bus.wr_req && !ack_prev && n < 20) begin step(); n++; end
        bus.wr_req = 0;
        step(); step();
        check_frame("rand_frame");

`ifdef VRAM_CLEAR_EN
        // Clear with interleaved reads and a write left pending throughout.
        bus.clr_req = 1; bus.clr_rgb = 3'b001;
        step();
        bus.clr_req = 0; bus.clr_rgb = 3'b110;
        bus.wr_req = 1; bus.wr_row = 10; bus.wr_col = 20; bus.wr_rgb = 3'b100;
        n = 0;
        while (clearing && n < 20000) begin
            rand_read(25, 103);
            if (n == 50) bus.clr_req = 1;
            if (n == 51) bus.clr_req = 0;
            step();
            n++;
        end
        check("t5_done", clearing, 0);
        check("t5_busy_low", bus.clr_busy, 0);
        bus.rd_req = 0;
        bus.clr_req = 0;
        step();
        check("t5_wr_after", bus.wr_ack, 1);
        bus.wr_req = 0;
        step();
        check_frame("t5_frame");

        // Reset in the cycle the write to address 4000 is in flight.
        bus.clr_req = 1; bus.clr_rgb = 3'b010;
        step();
        bus.clr_req = 0;
        n = 0;
        while (ccnt != 4000 && n < 20000) begin step(); n++; end
        check("t6_reach", ccnt, 4000);
        @(posedge i_clk);
        #1 i_rst = 1;
        #1 check_idle_outputs("t6_reset");
        prev_rd = 0; ack_prev = 0; clearing = 0; ccnt = 0;
        @(negedge i_clk);
        i_rst = 0;
        step();
        check("t6_idle", bus.clr_busy, 0);
        bus.rd_req = 1; bus.rd_row = 7'(4000 / 128); bus.rd_col = 7'(4000 % 128);
        step();
        bus.rd_row = 7'(3999 / 128); bus.rd_col = 7'(3999 % 128);
        step();
        check("t6_keep_4000", bus.rd_rgb, 3'b001);
        bus.rd_req = 0;
        step();
        check("t6_clr_3999", bus.rd_rgb, 3'b010);
        step();
        check_frame("t6_frame");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
